rx_descrambler_sync: RTL
========================

// Module: rx_descrambler_sync
// PURPOSE
//   Receive-side counterpart of the 64b/66b TX scrambler. Takes gearbox-aligned 66-bit blocks
//   ({sync_header[1:0], payload[63:0]}) and descrambles the payload with the self-synchronising
//   x^58+x^39+1 polynomial. Runs a block-lock FSM on the sync headers and requests gearbox
//   bitslips until alignment is found. Sits between the RX gearbox and the Aurora block decoder.
// PARAMETERS
//   LOCK_CNT    32  consecutive valid headers required to declare lock
//   SH_WINDOW   64  blocks per bad-header monitoring window while locked
//   UNLOCK_BAD  16  invalid headers within one window that drop lock
//   SLIP_WAIT   16  valid_i blocks ignored after each bitslip request (gearbox settle)
// PORTS
//   clk_i        in   1   block clock
//   rst_n_i      in   1   asynchronous reset, active low
//   data_i       in   64  scrambled payload, bit 0 transmitted first
//   sync_i       in   2   sync header (2'b01 data, 2'b10 control)
//   valid_i      in   1   data_i/sync_i hold a new block this cycle
//   data_o       out  64  descrambled payload
//   sync_o       out  2   sync header, delayed to match data_o
//   valid_o      out  1   data_o/sync_o valid
//   locked_o     out  1   block lock achieved
//   bitslip_o    out  1   one-cycle request to slip the gearbox by one bit
//   err_cnt_o    out  16  invalid-header count while locked (see CONFIGURATION)
//   err_clr_i    in   1   synchronous clear of err_cnt_o
// BEHAVIOUR
//   Reset (async, rst_n_i=0): data_o=0, sync_o=2'b00, valid_o=0, locked_o=0, bitslip_o=0,
//     err_cnt_o=0; descrambler history s[57:0] = all 1s; FSM=UNLOCKED; all counters 0.
//   Descrambler: for i=0..63 on a valid_i block: out[i] = data_i[i] ^ s[38] ^ s[57];
//     s = {s[56:0], data_i[i]}. History shifts by scrambled (input) bits and advances only on
//     valid_i. Descrambling is applied regardless of lock state and regardless of sync_i value.
//   Latency: 1 cycle. valid_o = valid_i registered; data_o/sync_o are updated only on valid_i
//     and otherwise hold their value.
//   Header check: sync_i in {01,10} = good; {00,11} = bad. Evaluated only when valid_i=1.
//   FSM UNLOCKED: good -> good_cnt++; good_cnt reaching LOCK_CNT -> LOCKED, locked_o=1 on the
//     next edge. bad -> bitslip_o=1 for exactly one cycle, good_cnt=0, -> SLIP_HOLD.
//   FSM SLIP_HOLD: count valid_i blocks, headers ignored; after SLIP_WAIT blocks -> UNLOCKED.
//     bitslip_o is never asserted twice within SLIP_WAIT+1 valid blocks.
//   FSM LOCKED: win_cnt counts valid blocks 0..SH_WINDOW-1 then wraps to 0 and clears bad_cnt.
//     bad -> bad_cnt++; bad_cnt reaching UNLOCK_BAD within a window -> locked_o=0, bitslip_o=1
//     for one cycle, all counters cleared, -> SLIP_HOLD. A bad header on the wrap block counts
//     toward the new window.
//   valid_i=0: no counter, history or FSM advance; bitslip_o deasserts after its single cycle.
//   Reset mid-operation: asynchronously returns to reset values; lock must be re-acquired.
// CONFIGURATION
//   RX_ERR_CNT_EN defined: err_cnt_o increments on every bad header while LOCKED, saturates at
//     16'hFFFF; err_clr_i=1 clears it (clear wins over a simultaneous increment).
//   RX_ERR_CNT_EN undefined: counter not built; err_cnt_o tied to 16'h0000, err_clr_i ignored.
// TESTING
//   1. Reset, then one block data_i=64'h0, sync_i=2'b01, valid_i=1 -> next cycle
//      data_o=64'h03FF_FF80_0000_0000, sync_o=2'b01, valid_o=1, locked_o=0.
//   2. TX scrambler looped back, 300 random blocks with correct headers -> locked_o rises the
//      cycle after the 32nd block; data_o matches unscrambled TX data from block 2 onward.
//   3. Unlocked, one block with sync_i=2'b11 -> bitslip_o high exactly 1 cycle; next 16 bad
//      blocks produce no bitslip; the 17th bad block produces a second pulse.
//   4. Locked, 15 bad headers in a 64-block window -> stays locked; 16th bad in same window ->
//      locked_o=0 and one bitslip_o pulse the next cycle.
//   5. RX_ERR_CNT_EN defined: locked, 5 bad headers -> err_cnt_o=5; err_clr_i with a bad header
//      in the same cycle -> err_cnt_o=0; undefined -> err_cnt_o stays 0.
//   6. Assert rst_n_i mid-stream while locked -> all outputs 0 immediately, re-lock after 32 blocks.

Source files
------------

// File: rtl/rx_descrambler_sync.sv
// rx_descrambler_sync: 64b/66b RX descrambler (x^58+x^39+1) with sync-header block-lock FSM and bitslip requests.
// Optional macro RX_ERR_CNT_EN builds the locked-state bad-header counter driving err_cnt_o.
`default_nettype none

module rx_descrambler_sync #(
  parameter int LOCK_CNT   = 32,
  parameter int SH_WINDOW  = 64,
  parameter int UNLOCK_BAD = 16,
  parameter int SLIP_WAIT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] data_i,
  input  logic [1:0]  sync_i,
  input  logic        valid_i,
  output logic [63:0] data_o,
  output logic [1:0]  sync_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        bitslip_o,
  output logic [15:0] err_cnt_o,
  input  logic        err_clr_i
);

  localparam int c_good_w = $clog2(LOCK_CNT + 1);
  localparam int c_win_w  = $clog2(SH_WINDOW);
  localparam int c_bad_w  = $clog2(UNLOCK_BAD + 1);
  localparam int c_slip_w = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_SLIP_HOLD = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t              r_state;
  logic [57:0]         r_hist;
  logic [c_good_w-1:0] r_good_cnt;
  logic [c_win_w-1:0]  r_win_cnt;
  logic [c_bad_w-1:0]  r_bad_cnt;
  logic [c_slip_w-1:0] r_slip_cnt;
  logic                r_locked;
  logic                r_bitslip;

  logic [63:0] w_desc;
  logic [57:0] w_hist_nxt;
  logic        w_sh_good;
  logic        w_win_wrap;

  assign w_sh_good  = sync_i[1] ^ sync_i[0];
  assign w_win_wrap = (r_win_cnt == c_win_w'(SH_WINDOW - 1));

  // Self-synchronising: history is fed by the received (scrambled) bits, bit 0 first.
  always_comb begin
    logic [57:0] w_s;
    w_s    = r_hist;
    w_desc = '0;
    for (int i = 0; i < 64; i++) begin
      w_desc[i] = data_i[i] ^ w_s[38] ^ w_s[57];
      w_s       = {w_s[56:0], data_i[i]};
    end
    w_hist_nxt = w_s;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hist  <= '1;
      data_o  <= '0;
      sync_o  <= 2'b00;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        r_hist <= w_hist_nxt;
        data_o <= w_desc;
        sync_o <= sync_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_bad_cnt  <= '0;
      r_slip_cnt <= '0;
      r_locked   <= 1'b0;
      r_bitslip  <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      if (valid_i) begin
        case (r_state)
          ST_UNLOCKED: begin
            if (w_sh_good) begin
              if (r_good_cnt == c_good_w'(LOCK_CNT - 1)) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_good_cnt <= '0;
                r_win_cnt  <= '0;
                r_bad_cnt  <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + 1'b1;
              end
            end else begin
              r_bitslip  <= 1'b1;
              r_good_cnt <= '0;
              r_slip_cnt <= '0;
              r_state    <= ST_SLIP_HOLD;
            end
          end
          ST_SLIP_HOLD: begin
            if (r_slip_cnt == c_slip_w'(SLIP_WAIT - 1)) begin
              r_slip_cnt <= '0;
              r_state    <= ST_UNLOCKED;
            end else begin
              r_slip_cnt <= r_slip_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // A bad header on the wrapping block opens the new window's tally.
            if (w_win_wrap) begin
              r_win_cnt <= '0;
              r_bad_cnt <= w_sh_good ? '0 : c_bad_w'(1);
            end else if (!w_sh_good && (r_bad_cnt == c_bad_w'(UNLOCK_BAD - 1))) begin
              r_locked   <= 1'b0;
              r_bitslip  <= 1'b1;
              r_win_cnt  <= '0;
              r_bad_cnt  <= '0;
              r_good_cnt <= '0;
              r_slip_cnt <= '0;
              r_state    <= ST_SLIP_HOLD;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              if (!w_sh_good) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  assign locked_o  = r_locked;
  assign bitslip_o = r_bitslip;

`ifdef RX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (valid_i && (r_state == ST_LOCKED) && !w_sh_good && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr_i;
  assign err_cnt_o        = 16'h0000;
`endif

endmodule

`default_nettype wire
